fifo_rr_scheduler: RTL and testbench

Round-robin read scheduler that drains NUM_FIFOS input FIFOs into one shared output FIFO. It issues one-hot rd_enable to the input FIFOs, forwards the returned word with wr_enable to the output FIFO, and honours output backpressure. It also configures the almost-full/almost-empty thresholds of all FIFOs. It sits between the per-lane FIFOs and the downstream datapath.

---
 rtl/fifo_rr_scheduler_pkg.sv | 27 ++
 rtl/fifo_rr_scheduler_rr_grant.sv | 37 +++
 rtl/fifo_rr_scheduler.sv | 171 +++++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared definitions for the round-robin FIFO read scheduler.
//   state_t   : FSM state encodings (also driven on the debug 'state' port)
//   DEF_BAJO  : default almost-empty threshold
//   def_alto  : default almost-full threshold for a given address width
//   slice_lo  : low bit of FIFO 'idx' inside a packed data bus of width 'w' words
package fifo_rr_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int unsigned DEF_BAJO = 1;

    // Leaves two free slots below the top so in-flight words always fit.
    function automatic int unsigned def_alto(input int unsigned aw);
        return (32'd1 << aw) - 32'd3;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_grant.sv
// Combinational round-robin picker.
//   eligible   : request vector
//   last_grant : index granted most recently; search starts one above it
//   grant      : one-hot grant (zero when nothing is eligible)
//   grant_idx  : index of the granted bit
//   grant_vld  : any grant issued
module fifo_rr_scheduler_rr_grant #(
    parameter int NUM_FIFOS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_FIFOS-1:0] eligible,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_FIFOS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_vld
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate (last_grant itself) down to the
    // nearest (last_grant+1); the last hit wins, so the nearest has priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = NUM_FIFOS; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_FIFOS);
            if (eligible[cand]) begin
                grant_idx = cand;
                grant_vld = 1'b1;
            end
        end
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler draining NUM_FIFOS input FIFOs into one output FIFO.
//   clk, reset          : clock, async active-high reset
//   init                : enter INIT and latch thresholds from umbral_*_in
//   empty_fifo, almost_empty_fifo, error_in, almost_fifo_full : FIFO status
//   data_in             : packed input FIFO read data, FIFO i in slice i
//   rd_enable           : one-hot read strobe to the input FIFOs
//   wr_enable, data_out : write strobe / word to the output FIFO
//   umbral_alto/bajo    : thresholds broadcast to all FIFOs
//   state, idle         : debug state and IDLE flag
// Pipeline: grant -> rd_enable_q (read) -> pend_q (word on data_in)
//           -> wr_enable_q/data_out_q (write), i.e. two cycles rd to wr.
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int NUM_FIFOS     = 4,
    parameter int data_width    = 10,
    parameter int address_width = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            init,
    input  logic [address_width-1:0]        umbral_alto_in,
    input  logic [address_width-1:0]        umbral_bajo_in,
    input  logic [NUM_FIFOS-1:0]            empty_fifo,
    input  logic [NUM_FIFOS-1:0]            almost_empty_fifo,
    input  logic [NUM_FIFOS:0]              error_in,
    input  logic [NUM_FIFOS*data_width-1:0] data_in,
    input  logic                            almost_fifo_full,
    output logic [NUM_FIFOS-1:0]            rd_enable,
    output logic                            wr_enable,
    output logic [data_width-1:0]           data_out,
    output logic [address_width-1:0]        umbral_alto,
    output logic [address_width-1:0]        umbral_bajo,
    output logic [2:0]                      state,
    output logic                            idle
);

    localparam int IDX_W = $clog2(NUM_FIFOS);

    state_t                   state_q, state_d;
    logic [NUM_FIFOS-1:0]     rd_enable_q, rd_enable_d;
    logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
    logic                     pend_q, pend_d;
    logic [IDX_W-1:0]         pend_idx_q, pend_idx_d;
    logic                     wr_enable_q, wr_enable_d;
    logic [data_width-1:0]    data_out_q, data_out_d;
    logic [address_width-1:0] umbral_alto_q, umbral_alto_d;
    logic [address_width-1:0] umbral_bajo_q, umbral_bajo_d;
    logic                     idle_q, idle_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;

    logic [data_width-1:0]    din_arr [NUM_FIFOS];
    logic [NUM_FIFOS-1:0]     eligible, gnt;
    logic [IDX_W-1:0]         gnt_idx;
    logic                     gnt_vld;
    logic                     err, drained;

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_slice
        assign din_arr[i] = data_in[slice_lo(i, data_width) +: data_width];
    end

    assign err     = |error_in;
    assign drained = ~|rd_enable_q & ~pend_q;

    // A FIFO being read right now with <=1 word may still show non-empty
    // because its flags lag the read; skip it to avoid reading past the end.
    assign eligible = ~empty_fifo
                    & ~{NUM_FIFOS{almost_fifo_full | init}}
                    & ~(rd_enable_q & almost_empty_fifo);

    fifo_rr_scheduler_rr_grant #(
        .NUM_FIFOS (NUM_FIFOS),
        .IDX_W     (IDX_W)
    ) u_rr_grant (
        .eligible   (eligible),
        .last_grant (last_grant_q),
        .grant      (gnt),
        .grant_idx  (gnt_idx),
        .grant_vld  (gnt_vld)
    );

    always_comb begin
        state_d       = state_q;
        rd_enable_d   = '0;
        rd_idx_d      = rd_idx_q;
        pend_d        = |rd_enable_q;
        pend_idx_d    = rd_idx_q;
        wr_enable_d   = pend_q;
        data_out_d    = pend_q ? din_arr[pend_idx_q] : data_out_q;
        umbral_alto_d = umbral_alto_q;
        umbral_bajo_d = umbral_bajo_q;
        last_grant_d  = last_grant_q;
        case (state_q)
            ST_RESET: begin
                state_d       = ST_INIT;
                umbral_alto_d = address_width'(def_alto(address_width));
                umbral_bajo_d = address_width'(DEF_BAJO);
            end
            ST_INIT: begin
                umbral_alto_d = umbral_alto_in;
                umbral_bajo_d = umbral_bajo_in;
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (err)                 state_d = ST_ERROR;
                else if (init)           state_d = ST_INIT;
                else if (~&empty_fifo)   state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (err) begin
                    // The word on data_in now is captured this edge; the one
                    // still being read is dropped.
                    state_d = ST_ERROR;
                    pend_d  = 1'b0;
                end else if (init) begin
                    if (drained) state_d = ST_INIT;
                end else if (gnt_vld) begin
                    rd_enable_d  = gnt;
                    rd_idx_d     = gnt_idx;
                    last_grant_d = gnt_idx;
                end else if (&empty_fifo && drained) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                pend_d      = 1'b0;
                wr_enable_d = 1'b0;
                data_out_d  = data_out_q;
            end
            default: state_d = ST_RESET;
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RESET;
            rd_enable_q   <= '0;
            rd_idx_q      <= '0;
            pend_q        <= 1'b0;
            pend_idx_q    <= '0;
            wr_enable_q   <= 1'b0;
            data_out_q    <= '0;
            umbral_alto_q <= '0;
            umbral_bajo_q <= '0;
            idle_q        <= 1'b0;
            last_grant_q  <= IDX_W'(NUM_FIFOS - 1);
        end else begin
            state_q       <= state_d;
            rd_enable_q   <= rd_enable_d;
            rd_idx_q      <= rd_idx_d;
            pend_q        <= pend_d;
            pend_idx_q    <= pend_idx_d;
            wr_enable_q   <= wr_enable_d;
            data_out_q    <= data_out_d;
            umbral_alto_q <= umbral_alto_d;
            umbral_bajo_q <= umbral_bajo_d;
            idle_q        <= idle_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign rd_enable   = rd_enable_q;
    assign wr_enable   = wr_enable_q;
    assign data_out    = data_out_q;
    assign umbral_alto = umbral_alto_q;
    assign umbral_bajo = umbral_bajo_q;
    assign state       = state_q;
    assign idle        = idle_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: behavioural input FIFOs, expected
// output words queued by the stimulus, checked by an independent monitor.
module tb_fifo_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 10;
    localparam int AW = 8;

    logic              clk, reset, init, almost_fifo_full;
    logic [AW-1:0]     umbral_alto_in, umbral_bajo_in;
    logic [N-1:0]      empty_fifo, almost_empty_fifo;
    logic [N:0]        error_in;
    logic [N*DW-1:0]   data_in;
    logic [N-1:0]      rd_enable;
    logic              wr_enable;
    logic [DW-1:0]     data_out;
    logic [AW-1:0]     umbral_alto, umbral_bajo;
    logic [2:0]        state;
    logic              idle;

    fifo_rr_scheduler #(.NUM_FIFOS(N), .data_width(DW), .address_width(AW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_alto_in(umbral_alto_in), .umbral_bajo_in(umbral_bajo_in),
        .empty_fifo(empty_fifo), .almost_empty_fifo(almost_empty_fifo),
        .error_in(error_in), .data_in(data_in), .almost_fifo_full(almost_fifo_full),
        .rd_enable(rd_enable), .wr_enable(wr_enable), .data_out(data_out),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .state(state), .idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    logic [DW-1:0] fq [N][$];
    logic [DW-1:0] exp_q [$];
    logic [N-1:0]  rd_log [$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_flags();
        for (int i = 0; i < N; i++) begin
            empty_fifo[i]        = (fq[i].size() == 0);
            almost_empty_fifo[i] = (fq[i].size() <= 1);
        end
    endtask

    task automatic load(input int f, input logic [DW-1:0] w);
        fq[f].push_back(w);
        set_flags();
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < N; i++) fq[i].delete();
        set_flags();
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string name);
        int k = 0;
        while (state !== s && k < bound) begin
            step(1);
            k++;
        end
        check(name, state, s);
    endtask

    task automatic wait_rd(input int bound, input string name);
        int k = 0;
        while (rd_enable == '0 && k < bound) begin
            step(1);
            k++;
        end
        check(name, int'(rd_enable != '0), 1);
    endtask

    // Behavioural input FIFOs: a read pops on the edge, the word and the
    // updated flags appear in the following cycle.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_enable[i]) begin
                n_tests++;
                if (fq[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL underflow fifo%0d: read while empty", i);
                end else begin
                    data_in[i*DW +: DW] <= fq[i].pop_front();
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            empty_fifo[i]        <= (fq[i].size() == 0);
            almost_empty_fifo[i] <= (fq[i].size() <= 1);
        end
    end

    // Monitor: every write is matched against the expected-word queue.
    always @(negedge clk) begin
        if (rd_enable != '0) begin
            rd_log.push_back(rd_enable);
            n_tests++;
            if ($countones(rd_enable) != 1) begin
                n_fail++;
                $display("FAIL rd_onehot: got %b, expected one-hot", rd_enable);
            end
        end
        if (wr_enable) begin
            wr_cnt++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got 0x%0h, expected no write", data_out);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_fail++;
                    $display("FAIL write_data: got 0x%0h, expected 0x%0h", data_out, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int wr0, rd0;
    logic [N-1:0] seq3 [5];

    initial begin
        reset = 1'b1; init = 1'b0; almost_fifo_full = 1'b0;
        umbral_alto_in = '0; umbral_bajo_in = '0;
        error_in = '0; data_in = '0;
        empty_fifo = '1; almost_empty_fifo = '1;
        seq3[0] = 4'b0001; seq3[1] = 4'b0010; seq3[2] = 4'b0100;
        seq3[3] = 4'b1000; seq3[4] = 4'b0001;
        step(3);
        check("reset_state", state, 0);
        check("reset_rd", rd_enable, 0);
        check("reset_wr", wr_enable, 0);
        check("reset_alto", umbral_alto, 0);
        check("reset_idle", idle, 0);

        // 1: init with thresholds
        reset = 1'b0; init = 1'b1; umbral_alto_in = 8'd253; umbral_bajo_in = 8'd1;
        step(1);
        check("t1_state_init", state, 1);
        step(1);
        check("t1_alto", umbral_alto, 253);
        check("t1_bajo", umbral_bajo, 1);
        init = 1'b0;
        step(1);
        check("t1_state_idle", state, 2);
        check("t1_idle", idle, 1);
        check("t1_no_reads", rd_log.size(), 0);
        check("t1_no_writes", wr_cnt, 0);

        // 3: all four FIFOs, two words each, last_grant starts at 3
        rd_log.delete();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++) begin
                load(i, DW'(10'h100 + i*16 + j));
                exp_q.push_back(DW'(10'h100 + i*16 + j));
            end
        wait_state(3'd3, 5, "t3_active");
        wait_state(3'd2, 60, "t3_back_idle");
        check("t3_rd_count", rd_log.size(), 8);
        for (int k = 0; k < 5; k++)
            if (k < rd_log.size()) check($sformatf("t3_rd_seq%0d", k), rd_log[k], seq3[k]);
        check("t3_exp_drained", exp_q.size(), 0);

        // 2: FIFO0 with three words, latency and no over-read
        rd_log.delete();
        load(0, 10'h090); load(0, 10'h1A9); load(0, 10'h239);
        exp_q.push_back(10'h090); exp_q.push_back(10'h1A9); exp_q.push_back(10'h239);
        wait_rd(10, "t2_first_rd");
        check("t2_rd_fifo0", rd_enable, 1);
        step(2);
        check("t2_wr_latency", wr_enable, 1);
        check("t2_first_word", data_out, 10'h090);
        wait_state(3'd2, 30, "t2_back_idle");
        check("t2_rd_count", rd_log.size(), 3);
        check("t2_exp_drained", exp_q.size(), 0);
        step(2);
        check("t2_data_hold", data_out, 10'h239);

        // 4: backpressure mid-stream
        rd_log.delete();
        wr0 = wr_cnt;
        for (int j = 0; j < 6; j++) begin
            load(1, DW'(10'h300 + j));
            exp_q.push_back(DW'(10'h300 + j));
        end
        wait_rd(10, "t4_first_rd");
        step(1);
        check("t4_second_rd", rd_enable, 4'b0010);
        almost_fifo_full = 1'b1;
        step(1);
        check("t4_rd_stops", rd_enable, 0);
        step(5);
        check("t4_no_rd_while_full", rd_log.size(), 2);
        check("t4_inflight_writes", wr_cnt - wr0, 2);
        almost_fifo_full = 1'b0;
        step(1);
        check("t4_rd_resumes", rd_enable, 4'b0010);
        wait_state(3'd2, 40, "t4_back_idle");
        check("t4_exp_drained", exp_q.size(), 0);

        // 5: error while ACTIVE, only reset recovers
        load(1, 10'h3F0); load(1, 10'h3F1); load(1, 10'h3F2);
        wait_rd(10, "t5_first_rd");
        error_in[N] = 1'b1;
        step(1);
        check("t5_state_error", state, 4);
        check("t5_rd_off", rd_enable, 0);
        check("t5_wr_off", wr_enable, 0);
        rd0 = rd_log.size();
        wr0 = wr_cnt;
        init = 1'b1;
        step(6);
        check("t5_stays_error", state, 4);
        check("t5_no_reads", rd_log.size(), rd0);
        check("t5_no_writes", wr_cnt, wr0);
        reset = 1'b1; error_in = '0; init = 1'b0;
        clear_fifos();
        step(1);
        check("t5_reset_state", state, 0);
        reset = 1'b0; init = 1'b1;
        step(1);
        check("t5_recover_init", state, 1);
        init = 1'b0;
        step(1);
        check("t5_recover_idle", state, 2);
        check("t5_alto_kept", umbral_alto, 253);

        // 6: half-cycle reset mid-burst, nothing stale written afterwards
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < N; i++) load(i, DW'(10'h040 + i*16 + j));
        exp_q.push_back(10'h040); exp_q.push_back(10'h050);
        wr0 = wr_cnt;
        wait_rd(10, "t6_first_rd");
        step(3);
        reset = 1'b1;
        #1;
        check("t6_async_rd", rd_enable, 0);
        check("t6_async_wr", wr_enable, 0);
        check("t6_async_data", data_out, 0);
        check("t6_async_state", state, 0);
        clear_fifos();
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(1);
        check("t6_state_reset", state, 0);
        step(1);
        check("t6_state_init", state, 1);
        step(4);
        check("t6_state_idle", state, 2);
        check("t6_writes", wr_cnt - wr0, 2);
        check("t6_exp_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
